rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single instruction-ROM read port between two requesters: m0 = CPU fetch
//  path, m1 = secondary reader (debug/loader). Sits between the core and inst_rom
//  inside the top level. Round-robin arbitration, one outstanding access at a time.
//  Each request gets a registered grant and a registered, one-cycle response pulse.
// PARAMETERS
//  ADDR_W   32  width of request/ROM address
//  DATA_W   32  width of ROM data word
//  ROM_LAT  0   extra ROM read cycles (0 = combinational ROM); legal 0..3
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       synchronous, active-low reset
//  m0_req_i     in   1       m0 request; addr valid while high
//  m0_addr_i    in   ADDR_W  m0 read address
//  m0_gnt_o     out  1       1-cycle pulse: m0 request accepted this cycle
//  m0_rvalid_o  out  1       1-cycle pulse: m0_rdata_o valid
//  m0_rdata_o   out  DATA_W  m0 read data (held until next m0 response)
//  m1_req_i / m1_addr_i / m1_gnt_o / m1_rvalid_o / m1_rdata_o: same as m0, for m1
//  rom_ce_o     out  1       ROM chip enable
//  rom_addr_o   out  ADDR_W  ROM address; 0 whenever rom_ce_o=0
//  rom_data_i   in   DATA_W  ROM read data
//  busy_o       out  1       high in ACCESS state
// BEHAVIOUR
//  Reset (rst=0 at a clock edge): state=IDLE, all outputs 0, rdata regs 0,
//   wait counter 0, last_grant=1 (so m0 wins the first tie). Reset mid-access aborts it:
//   no rvalid is ever issued for it.
//  FSM IDLE -> ACCESS -> RESP:
//   IDLE:   any req -> assert gnt for the winner (comb from req + state), capture
//           addr and owner, go ACCESS. No req -> stay IDLE.
//   ACCESS: rom_ce_o=1, rom_addr_o=captured addr, counter counts 0..ROM_LAT; on
//           count==ROM_LAT capture rom_data_i into owner's rdata reg, go RESP.
//   RESP:   owner's rvalid_o=1 for this cycle. A new grant may be issued in this same
//           cycle (same rules as IDLE) -> ACCESS; else -> IDLE.
//  Timing: gnt in cycle T -> rom_ce_o high cycles T+1..T+1+ROM_LAT -> rvalid in
//   cycle T+2+ROM_LAT. Back-to-back throughput: one access per ROM_LAT+2 cycles.
//  Arbitration: only one req -> grant it. Both req -> grant the one NOT equal to
//   last_grant; last_grant updates on every grant. No grant while in ACCESS.
//  Handshake: requester holds req+addr stable until gnt; req dropped before gnt is
//   legal and has no effect. req still high the cycle after gnt = a new request.
//  rdata_o of the non-owner never changes; rvalid_o of both never high together.
//  Address passed through unmodified (no alignment/masking); width rules: none.
// TESTING
//  1 ROM_LAT=0, m0 req addr 0x0000_0004, ROM returns 0x3401_1100 -> m0_gnt at T,
//    rom_ce T+1 with addr 0x4, m0_rvalid at T+2 with rdata 0x3401_1100; m1 outputs 0.
//  2 Both req held high continuously from reset -> grants alternate m0,m1,m0,m1,
//    one grant every 2 cycles, first grant to m0; rvalid owners follow same order.
//  3 ROM_LAT=2, m1 req addr 0x20 -> rom_ce high 3 cycles, m1_rvalid at T+4;
//    m0 req raised during ACCESS gets no gnt until RESP cycle T+4.
//  4 rst=0 asserted in cycle T+1 of an access -> next cycle all outputs 0, no rvalid
//    afterwards; first grant after release goes to m0 on a tie.
//  5 m0 req pulsed for 1 cycle while busy (dropped before gnt) -> never granted,
//    no rvalid, FSM returns IDLE after current RESP.
//  6 Idle with no requests for 10 cycles -> rom_ce_o=0, rom_addr_o=0, busy_o=0.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Two-port round-robin arbiter in front of a single instruction-ROM read port.
// One access in flight at a time: grant -> ACCESS (ROM_LAT+1 cycles) -> RESP pulse.
module rom_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // ROM_LAT is legal 0..3, so a 2-bit wait counter is enough
    localparam logic [1:0] LAT_LAST = 2'(ROM_LAT);

    state_t            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [1:0]        r_cnt;
    logic              r_ce;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_busy;

    logic              w_req  [2];
    logic [ADDR_W-1:0] w_addr [2];
    logic              w_gnt  [2];
    logic              w_can_grant;
    logic              w_any_gnt;
    logic              w_gnt_id;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic              w_capture;

    assign w_req[0]  = m0_req_i;
    assign w_req[1]  = m1_req_i;
    assign w_addr[0] = m0_addr_i;
    assign w_addr[1] = m1_addr_i;

    // On a tie the port that did not win last time is served; reset gates grants off
    assign w_can_grant = rst && (r_state != ST_ACCESS);
    assign w_gnt[0]    = w_can_grant && w_req[0] && (!w_req[1] || r_last_grant);
    assign w_gnt[1]    = w_can_grant && w_req[1] && (!w_req[0] || !r_last_grant);
    assign w_any_gnt   = w_gnt[0] || w_gnt[1];
    assign w_gnt_id    = w_gnt[1];
    assign w_gnt_addr  = w_gnt_id ? w_addr[1] : w_addr[0];
    assign w_capture   = (r_state == ST_ACCESS) && (r_cnt == LAT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= 2'd0;
            r_ce         <= 1'b0;
            r_rom_addr   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_any_gnt) begin
                        r_state      <= ST_ACCESS;
                        r_owner      <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_cnt        <= 2'd0;
                        r_ce         <= 1'b1;
                        r_rom_addr   <= w_gnt_addr;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_ce       <= 1'b0;
                        r_rom_addr <= '0;
                        r_busy     <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (w_capture) begin
                        r_state    <= ST_RESP;
                        r_ce       <= 1'b0;
                        r_rom_addr <= '0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ce       <= 1'b0;
                    r_rom_addr <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Per-port response registers: only the owner's data word ever changes
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              r_rvalid;
        logic [DATA_W-1:0] r_rdata;
        logic              w_mine;

        assign w_mine = w_capture && (r_owner == 1'(gi));

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_rvalid <= 1'b0;
                r_rdata  <= '0;
            end else begin
                r_rvalid <= w_mine;
                if (w_mine) begin
                    r_rdata <= rom_data_i;
                end
            end
        end
    end

    assign m0_gnt_o    = w_gnt[0];
    assign m1_gnt_o    = w_gnt[1];
    assign m0_rvalid_o = g_port[0].r_rvalid;
    assign m1_rvalid_o = g_port[1].r_rvalid;
    assign m0_rdata_o  = g_port[0].r_rdata;
    assign m1_rdata_o  = g_port[1].r_rdata;
    assign rom_ce_o    = r_ce;
    assign rom_addr_o  = r_rom_addr;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: two instances (ROM_LAT=0 and ROM_LAT=2) driven from one
// per-cycle vector table, with a response scoreboard per instance.
module tb_rom_port_arbiter;

    typedef struct {
        logic        sel;
        logic        rs;
        logic        m0r;
        logic [31:0] a0;
        logic        m1r;
        logic [31:0] a1;
        logic [5:0]  flags;   // {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rom_ce, busy}
        logic [31:0] eaddr;
    } vec_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req    [2];
    logic [31:0] m0_addr   [2];
    logic        m1_req    [2];
    logic [31:0] m1_addr   [2];
    logic        m0_gnt    [2];
    logic        m1_gnt    [2];
    logic        m0_rv     [2];
    logic        m1_rv     [2];
    logic [31:0] m0_rdata  [2];
    logic [31:0] m1_rdata  [2];
    logic        rom_ce    [2];
    logic [31:0] rom_addr  [2];
    logic [31:0] rom_data  [2];
    logic        busy      [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];
    sb_t  sbq[2][$];
    sb_t  mon_e;
    logic [31:0] exp_rd[2][2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_f(input logic [31:0] addr);
        if (addr == 32'h4) return 32'h3401_1100;
        return (addr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    assign rom_data[0] = rom_f(rom_addr[0]);
    assign rom_data[1] = rom_f(rom_addr[1]);

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LAT(0)) u_dut_lat0 (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req[0]), .m0_addr_i(m0_addr[0]), .m0_gnt_o(m0_gnt[0]),
        .m0_rvalid_o(m0_rv[0]), .m0_rdata_o(m0_rdata[0]),
        .m1_req_i(m1_req[0]), .m1_addr_i(m1_addr[0]), .m1_gnt_o(m1_gnt[0]),
        .m1_rvalid_o(m1_rv[0]), .m1_rdata_o(m1_rdata[0]),
        .rom_ce_o(rom_ce[0]), .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0]),
        .busy_o(busy[0])
    );

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LAT(2)) u_dut_lat2 (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req[1]), .m0_addr_i(m0_addr[1]), .m0_gnt_o(m0_gnt[1]),
        .m0_rvalid_o(m0_rv[1]), .m0_rdata_o(m0_rdata[1]),
        .m1_req_i(m1_req[1]), .m1_addr_i(m1_addr[1]), .m1_gnt_o(m1_gnt[1]),
        .m1_rvalid_o(m1_rv[1]), .m1_rdata_o(m1_rdata[1]),
        .rom_ce_o(rom_ce[1]), .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1]),
        .busy_o(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input logic sel, input logic rs, input logic m0r, input logic [31:0] a0,
                       input logic m1r, input logic [31:0] a1, input logic [5:0] flags,
                       input logic [31:0] eaddr);
        vec_t v;
        v.sel = sel; v.rs = rs; v.m0r = m0r; v.a0 = a0; v.m1r = m1r; v.a1 = a1;
        v.flags = flags; v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    // Response monitor: every rvalid must match the oldest outstanding grant
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (m0_rv[d] && m1_rv[d])
                    chk($sformatf("dut%0d_both_rvalid", d), 32'd1, 32'd0);
                if (m0_rv[d] || m1_rv[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("dut%0d_unexpected_rvalid", d), 32'd1, 32'd0);
                    end else begin
                        mon_e = sbq[d].pop_front();
                        exp_rd[d][mon_e.owner] = mon_e.data;
                        chk($sformatf("dut%0d_rvalid_owner", d), 32'(m1_rv[d]), 32'(mon_e.owner));
                        chk($sformatf("dut%0d_rvalid_cycle", d), 32'(cyc), 32'(mon_e.due));
                    end
                end else if (sbq[d].size() > 0 && sbq[d][0].due <= cyc) begin
                    mon_e = sbq[d].pop_front();
                    chk($sformatf("dut%0d_missing_rvalid", d), 32'd0, 32'd1);
                end
                chk($sformatf("dut%0d_m0_rdata", d), m0_rdata[d], exp_rd[d][0]);
                chk($sformatf("dut%0d_m1_rdata", d), m1_rdata[d], exp_rd[d][1]);
            end
        end
    end

    initial begin
        vec_t r;
        int   s;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m0_req[d] = 1'b0; m1_req[d] = 1'b0; m0_addr[d] = '0; m1_addr[d] = '0;
            exp_rd[d][0] = '0; exp_rd[d][1] = '0;
        end

        // ROM_LAT=0: single m0 read
        add(0, 1, 1, 32'h4,   0, 32'h0,   6'b100000, 32'h0);
        add(0, 1, 0, 32'h0,   0, 32'h0,   6'b000011, 32'h4);
        add(0, 1, 0, 32'h0,   0, 32'h0,   6'b001000, 32'h0);
        add(0, 0, 0, 32'h0,   0, 32'h0,   6'b000000, 32'h0);
        // both requesting from reset: m0, m1, m0, m1
        add(0, 1, 1, 32'h100, 1, 32'h200, 6'b100000, 32'h0);
        add(0, 1, 1, 32'h100, 1, 32'h200, 6'b000011, 32'h100);
        add(0, 1, 1, 32'h100, 1, 32'h200, 6'b011000, 32'h0);
        add(0, 1, 1, 32'h100, 1, 32'h200, 6'b000011, 32'h200);
        add(0, 1, 1, 32'h100, 1, 32'h200, 6'b100100, 32'h0);
        add(0, 1, 1, 32'h100, 1, 32'h200, 6'b000011, 32'h100);
        add(0, 1, 1, 32'h100, 1, 32'h200, 6'b011000, 32'h0);
        add(0, 1, 0, 32'h0,   0, 32'h0,   6'b000011, 32'h200);
        add(0, 1, 0, 32'h0,   0, 32'h0,   6'b000100, 32'h0);
        // ten idle cycles
        for (int k = 0; k < 10; k++) add(0, 1, 0, 32'h0, 0, 32'h0, 6'b000000, 32'h0);
        // reset in the middle of an access, then a tie goes to m0
        add(0, 1, 1, 32'h40,  0, 32'h0,   6'b100000, 32'h0);
        add(0, 0, 0, 32'h0,   0, 32'h0,   6'b000011, 32'h40);
        add(0, 1, 0, 32'h0,   0, 32'h0,   6'b000000, 32'h0);
        add(0, 1, 1, 32'h44,  1, 32'h48,  6'b100000, 32'h0);
        add(0, 1, 0, 32'h0,   0, 32'h0,   6'b000011, 32'h44);
        add(0, 1, 0, 32'h0,   0, 32'h0,   6'b001000, 32'h0);
        add(0, 1, 0, 32'h0,   0, 32'h0,   6'b000000, 32'h0);
        // ROM_LAT=2: m1 read, m0 waits through ACCESS, then a dropped m0 pulse
        add(1, 1, 0, 32'h0,   1, 32'h20,  6'b010000, 32'h0);
        add(1, 1, 0, 32'h0,   0, 32'h0,   6'b000011, 32'h20);
        add(1, 1, 1, 32'h30,  0, 32'h0,   6'b000011, 32'h20);
        add(1, 1, 1, 32'h30,  0, 32'h0,   6'b000011, 32'h20);
        add(1, 1, 1, 32'h30,  0, 32'h0,   6'b100100, 32'h0);
        add(1, 1, 0, 32'h0,   0, 32'h0,   6'b000011, 32'h30);
        add(1, 1, 1, 32'h34,  0, 32'h0,   6'b000011, 32'h30);
        add(1, 1, 0, 32'h0,   0, 32'h0,   6'b000011, 32'h30);
        add(1, 1, 0, 32'h0,   0, 32'h0,   6'b001000, 32'h0);
        add(1, 1, 0, 32'h0,   0, 32'h0,   6'b000000, 32'h0);
        add(1, 1, 0, 32'h0,   0, 32'h0,   6'b000000, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_dut%0d_outputs", d),
                {24'd0, m0_gnt[d], m1_gnt[d], m0_rv[d], m1_rv[d], rom_ce[d], busy[d], 2'b00}, 32'd0);
            chk($sformatf("reset_dut%0d_rom_addr", d), rom_addr[d], 32'd0);
            chk($sformatf("reset_dut%0d_rdata", d), m0_rdata[d] | m1_rdata[d], 32'd0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            s = int'(r.sel);
            @(posedge clk);
            #1;
            rst = r.rs;
            for (int d = 0; d < 2; d++) begin
                m0_req[d]  = (d == s) ? r.m0r : 1'b0;
                m0_addr[d] = (d == s) ? r.a0  : 32'h0;
                m1_req[d]  = (d == s) ? r.m1r : 1'b0;
                m1_addr[d] = (d == s) ? r.a1  : 32'h0;
                if (!r.rs) begin
                    sbq[d].delete();
                    exp_rd[d][0] = '0;
                    exp_rd[d][1] = '0;
                end
            end
            if (r.flags[5]) sbq[s].push_back('{owner: 1'b0, data: rom_f(r.a0), due: cyc + 2 + lat_of(s)});
            if (r.flags[4]) sbq[s].push_back('{owner: 1'b1, data: rom_f(r.a1), due: cyc + 2 + lat_of(s)});
            @(negedge clk);
            $display("row %0d dut%0d: gnt=%b%b rvalid=%b%b ce=%b addr=0x%0h busy=%b",
                     i, s, m0_gnt[s], m1_gnt[s], m0_rv[s], m1_rv[s], rom_ce[s], rom_addr[s], busy[s]);
            chk($sformatf("row%0d_m0_gnt", i),    32'(m0_gnt[s]), 32'(r.flags[5]));
            chk($sformatf("row%0d_m1_gnt", i),    32'(m1_gnt[s]), 32'(r.flags[4]));
            chk($sformatf("row%0d_m0_rvalid", i), 32'(m0_rv[s]),  32'(r.flags[3]));
            chk($sformatf("row%0d_m1_rvalid", i), 32'(m1_rv[s]),  32'(r.flags[2]));
            chk($sformatf("row%0d_rom_ce", i),    32'(rom_ce[s]), 32'(r.flags[1]));
            chk($sformatf("row%0d_busy", i),      32'(busy[s]),   32'(r.flags[0]));
            chk($sformatf("row%0d_rom_addr", i),  rom_addr[s],    r.eaddr);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            chk($sformatf("dut%0d_scoreboard_drained", d), 32'(sbq[d].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
